// File: rtl/jtframe_capture_pkg.sv
// Shared state encoding and default widths for the frame-synchronous capture controller.
package jtframe_capture_pkg;

  localparam int unsigned DEF_DW = 16;
  localparam int unsigned DEF_AW = 10;
  localparam int unsigned DEF_FW = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_DL  = 3'd1,
    WAIT_FRM = 3'd2,
    CAPTURE  = 3'd3,
    DONE     = 3'd4
  } cap_state_t;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port buffer: write on port A, registered read on port B (old data on collision).
module jtframe_dual_ram #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we_a,
  input  logic [AW-1:0] i_addr_a,
  input  logic [DW-1:0] i_data_a,
  input  logic [AW-1:0] i_addr_b,
  output logic [DW-1:0] o_q_b
);

  logic [DW-1:0] r_mem [0:(2**AW)-1];

  always_ff @(posedge i_clk) begin
    if (i_we_a) r_mem[i_addr_a] <= i_data_a;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) o_q_b <= '0;
    else          o_q_b <= r_mem[i_addr_b];
  end

endmodule

// File: rtl/jtframe_capture_ctrl.sv
// Frame-synchronous probe capture into an internal buffer with host readback.
// Define CAPTURE_RING_EN for ring-buffer mode; default is linear (stop at full).
module jtframe_capture_ctrl
  import jtframe_capture_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned FW = DEF_FW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          downloading,
  input  logic          arm,
  input  logic [FW-1:0] start_frame,
  input  logic [7:0]    frame_len,
  input  logic [DW-1:0] probe,
  input  logic          probe_valid,
  output logic [FW-1:0] frame_cnt,
  output logic          capturing,
  output logic          done,
  output logic [AW:0]   wr_cnt,
  output logic          wrapped,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  cap_state_t    r_state;
  logic          r_vs_l;
  logic          r_dl_l;
  logic [FW-1:0] r_frame_cnt;
  logic [FW-1:0] r_start;
  logic [7:0]    r_len;
  logic [7:0]    r_edges;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_wr_cnt;
  logic          r_capturing;
  logic          r_done;

  cap_state_t    w_state_nxt;
  logic          w_frm;
  logic          w_dl_fall;
  logic          w_dl_rise;
  logic          w_open;
  logic          w_close;
  logic          w_enter_cap;
  logic          w_enter_frm;
  logic          w_win;
  logic          w_room;
  logic          w_we;
  logic [FW-1:0] w_frame_inc;
  logic [7:0]    w_edges_inc;
  logic [AW-1:0] w_waddr;

  assign w_frm       = r_vs_l & ~vs;
  assign w_dl_fall   = r_dl_l & ~downloading;
  assign w_dl_rise   = ~r_dl_l & downloading;
  assign w_frame_inc = r_frame_cnt + 1'b1;
  assign w_edges_inc = r_edges + 8'd1;
  assign w_open      = w_frm & ~w_dl_fall & (w_frame_inc == r_start);
  assign w_close     = w_frm & (w_edges_inc == r_len);
  assign w_enter_cap = (r_state == WAIT_FRM) & arm & w_open;
  assign w_enter_frm = (w_state_nxt == WAIT_FRM) & (r_state != WAIT_FRM);

  // Window is half-open: the opening edge's sample is stored, the closing edge's is not.
  assign w_win   = arm & (((r_state == CAPTURE) & ~w_dl_rise & ~w_close) |
                          (w_enter_cap & (frame_len != 8'd0)));
  assign w_we    = w_win & probe_valid & w_room;
  assign w_waddr = w_enter_cap ? '0 : r_ptr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (arm) w_state_nxt = downloading ? WAIT_DL : WAIT_FRM;
      WAIT_DL:  if (!arm) w_state_nxt = IDLE;
                else if (w_dl_fall) w_state_nxt = WAIT_FRM;
      WAIT_FRM: if (!arm) w_state_nxt = IDLE;
                else if (w_open) w_state_nxt = (frame_len == 8'd0) ? DONE : CAPTURE;
      CAPTURE:  if (!arm) w_state_nxt = IDLE;
                else if (w_dl_rise) w_state_nxt = WAIT_DL;
                else if (w_close) w_state_nxt = DONE;
      DONE:     if (!arm) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_vs_l      <= 1'b0;
      r_dl_l      <= 1'b0;
      r_frame_cnt <= '0;
      r_capturing <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_vs_l      <= vs;
      r_dl_l      <= downloading;
      r_capturing <= (w_state_nxt == CAPTURE);
      r_done      <= (w_state_nxt == DONE);
      if (w_dl_fall)  r_frame_cnt <= '0;
      else if (w_frm) r_frame_cnt <= w_frame_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start  <= '0;
      r_len    <= '0;
      r_edges  <= '0;
      r_ptr    <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_enter_frm) r_start <= start_frame;
      if (w_enter_cap) begin
        r_len    <= frame_len;
        r_edges  <= '0;
        r_ptr    <= w_we ? AW'(1) : '0;
        r_wr_cnt <= w_we ? (AW+1)'(1) : '0;
      end else begin
        if ((r_state == CAPTURE) && w_frm && !w_close) r_edges <= w_edges_inc;
        if (w_we) begin
          r_ptr <= r_ptr + AW'(1);
          if (!r_wr_cnt[AW]) r_wr_cnt <= r_wr_cnt + (AW+1)'(1);
        end
      end
    end
  end

`ifdef CAPTURE_RING_EN
  logic r_wrapped;

  always_ff @(posedge clk) begin
    if (!rst_n)                         r_wrapped <= 1'b0;
    else if (w_enter_cap)               r_wrapped <= 1'b0;
    else if (w_we && (r_ptr == '1))     r_wrapped <= 1'b1;
  end

  assign w_room  = 1'b1;
  assign wrapped = r_wrapped;
`else
  // An opening write always fits: the counters are being cleared in that same cycle.
  assign w_room  = w_enter_cap | ~r_wr_cnt[AW];
  assign wrapped = 1'b0;
`endif

  jtframe_dual_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_we_a   (w_we),
    .i_addr_a (w_waddr),
    .i_data_a (probe),
    .i_addr_b (rd_addr),
    .o_q_b    (rd_data)
  );

  assign frame_cnt = r_frame_cnt;
  assign capturing = r_capturing;
  assign done      = r_done;
  assign wr_cnt    = r_wr_cnt;

endmodule
